// File: rtl/elev_pkg.sv
// Shared types, constants and hall-call bit-map helpers for the elevator slice.
package elev_pkg;

  localparam int unsigned NUM_FLOORS = 6;
  localparam int unsigned HALL_W     = 10;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  // Hall map: [0]=F0 up, [2f-1]/[2f]=Ff up/down for f=1..4, [9]=F5 down.
  function automatic logic [3:0] hall_up_idx(input logic [2:0] f);
    return (f == 3'd0) ? 4'd0 : ({f, 1'b0} - 4'd1);
  endfunction

  function automatic logic [3:0] hall_dn_idx(input logic [2:0] f);
    return (f == 3'(NUM_FLOORS - 1)) ? 4'd9 : {f, 1'b0};
  endfunction

  function automatic logic [HALL_W-1:0] hall_up_mask(input logic [2:0] f);
    logic [HALL_W-1:0] m;
    m = '0;
    if (f < 3'(NUM_FLOORS - 1)) m[hall_up_idx(f)] = 1'b1;
    return m;
  endfunction

  function automatic logic [HALL_W-1:0] hall_dn_mask(input logic [2:0] f);
    logic [HALL_W-1:0] m;
    m = '0;
    if (f > 3'd0 && f < 3'(NUM_FLOORS)) m[hall_dn_idx(f)] = 1'b1;
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [2:0] f);
    return NUM_FLOORS'(1) << f;
  endfunction

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] r, input logic [2:0] f);
    logic a;
    a = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++)
      if (3'(i) > f && r[3'(i)]) a = 1'b1;
    return a;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] r, input logic [2:0] f);
    logic a;
    a = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++)
      if (3'(i) < f && r[3'(i)]) a = 1'b1;
    return a;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done is high while the count sits at 1 (last cycle of an interval).
module cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - W'(1);
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/request_scheduler.sv
// Collective (SCAN) car controller serving latched car/hall calls over 6 floors.
// Optional DOOR_HOLD_EN adds a door_hold input that keeps the door open during dwell.
module request_scheduler
  import elev_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 3,
  parameter int unsigned TIMER_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] req_in,
  input  logic [HALL_W-1:0]     req_out,
`ifdef DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  output logic [NUM_FLOORS-1:0] clr_in,
  output logic [HALL_W-1:0]     clr_out,
  output logic [2:0]            cur_floor,
  output logic [1:0]            dir,
  output logic                  door_open,
  output logic                  moving
);

  localparam logic [TIMER_W-1:0] TRAVEL_T = TIMER_W'(TRAVEL_CYCLES);
  localparam logic [TIMER_W-1:0] DOOR_T   = TIMER_W'(DOOR_CYCLES);

  state_t                state, state_n;
  logic [2:0]            floor_n, arr_floor;
  logic [1:0]            dir_n;
  logic [NUM_FLOORS-1:0] clr_in_n, up_req, dn_req, any_req, new_in;
  logic [HALL_W-1:0]     clr_out_n, fwd_mask, back_mask, serve_mask, new_out;
  logic                  t_load, t_done, beyond, above, below, go_up, go_dn;
  logic [TIMER_W-1:0]    t_val;

  cycle_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  always_comb begin
    up_req = '0;
    dn_req = '0;
    for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
      up_req[3'(f)] = |(req_out & hall_up_mask(3'(f)));
      dn_req[3'(f)] = |(req_out & hall_dn_mask(3'(f)));
    end
  end

  assign any_req = req_in | up_req | dn_req;
  assign above   = any_above(any_req, cur_floor);
  assign below   = any_below(any_req, cur_floor);

  always_comb begin
    state_n    = state;
    floor_n    = cur_floor;
    dir_n      = dir;
    clr_in_n   = '0;
    clr_out_n  = '0;
    t_load     = 1'b0;
    t_val      = TRAVEL_T;
    go_up      = 1'b0;
    go_dn      = 1'b0;
    arr_floor  = (state == MOVE_UP) ? cur_floor + 3'd1 : cur_floor - 3'd1;
    beyond     = (state == MOVE_UP) ? any_above(any_req, arr_floor)
                                    : any_below(any_req, arr_floor);
    fwd_mask   = (state == MOVE_UP) ? hall_up_mask(arr_floor) : hall_dn_mask(arr_floor);
    back_mask  = (state == MOVE_UP) ? hall_dn_mask(arr_floor) : hall_up_mask(arr_floor);
    serve_mask = ((dir != DIR_DOWN) ? hall_up_mask(cur_floor) : '0) |
                 ((dir != DIR_UP)   ? hall_dn_mask(cur_floor) : '0);
    // Bits whose clear pulse is in flight are still set upstream; don't re-serve them.
    new_in     = floor_bit(cur_floor) & req_in & ~clr_in;
    new_out    = serve_mask & req_out & ~clr_out;

    case (state)
      IDLE: begin
        if (any_req[cur_floor]) begin
          state_n   = DOOR_OPEN;
          t_load    = 1'b1;
          t_val     = DOOR_T;
          clr_in_n  = floor_bit(cur_floor) & req_in;
          clr_out_n = (hall_up_mask(cur_floor) | hall_dn_mask(cur_floor)) & req_out;
        end else if (above) begin
          state_n = MOVE_UP;
          dir_n   = DIR_UP;
          t_load  = 1'b1;
        end else if (below) begin
          state_n = MOVE_DOWN;
          dir_n   = DIR_DOWN;
          t_load  = 1'b1;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (t_done) begin
          floor_n = arr_floor;
          if (req_in[arr_floor] || |(req_out & fwd_mask) || !beyond) begin
            state_n   = DOOR_OPEN;
            t_load    = 1'b1;
            t_val     = DOOR_T;
            clr_in_n  = floor_bit(arr_floor) & req_in;
            clr_out_n = (fwd_mask | (back_mask & {HALL_W{!beyond}})) & req_out;
            if (!beyond) dir_n = (state == MOVE_UP) ? DIR_DOWN : DIR_UP;
          end else begin
            t_load = 1'b1;
          end
        end
      end

      DOOR_OPEN: begin
        if (|new_in || |new_out) begin
          clr_in_n  = new_in;
          clr_out_n = new_out;
          t_load    = 1'b1;
          t_val     = DOOR_T;
        end
`ifdef DOOR_HOLD_EN
        else if (door_hold) begin
          t_load = 1'b1;
          t_val  = DOOR_T;
        end
`endif
        else if (t_done) begin
          if (dir == DIR_DOWN) begin
            go_dn = below;
            go_up = !below && above;
          end else begin
            go_up = above;
            go_dn = !above && below;
          end
          if (go_up) begin
            state_n = MOVE_UP;
            dir_n   = DIR_UP;
            t_load  = 1'b1;
          end else if (go_dn) begin
            state_n = MOVE_DOWN;
            dir_n   = DIR_DOWN;
            t_load  = 1'b1;
          end else begin
            state_n = IDLE;
            dir_n   = DIR_NONE;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur_floor <= '0;
      dir       <= DIR_NONE;
      clr_in    <= '0;
      clr_out   <= '0;
    end else begin
      state     <= state_n;
      cur_floor <= floor_n;
      dir       <= dir_n;
      clr_in    <= clr_in_n;
      clr_out   <= clr_out_n;
    end
  end

  assign door_open = (state == DOOR_OPEN);
  assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);

endmodule

// File: tb/tb_request_scheduler.sv
// Directed bench for request_scheduler (TRAVEL_CYCLES=4, DOOR_CYCLES=3) with an input_module-style request latch.
module tb_request_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       kill;
  logic [5:0] car_lat, car_press;
  logic [9:0] hall_lat, hall_press;
`ifdef DOOR_HOLD_EN
  logic       door_hold;
`endif
  logic [5:0] clr_in;
  logic [9:0] clr_out;
  logic [2:0] cur_floor;
  logic [1:0] dir;
  logic       door_open, moving;

  int checks = 0;
  int errors = 0;

  request_scheduler #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(3), .TIMER_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (car_lat),
    .req_out   (hall_lat),
`ifdef DOOR_HOLD_EN
    .door_hold (door_hold),
`endif
    .clr_in    (clr_in),
    .clr_out   (clr_out),
    .cur_floor (cur_floor),
    .dir       (dir),
    .door_open (door_open),
    .moving    (moving)
  );

  always #5 clk = ~clk;

  // Request latch: set by presses, cleared by the scheduler's pulses.
  always @(posedge clk) begin
    if (kill) begin
      car_lat  <= '0;
      hall_lat <= '0;
    end else begin
      car_lat  <= (car_lat & ~clr_in) | car_press;
      hall_lat <= (hall_lat & ~clr_out) | hall_press;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    kill = 1'b1;
    car_press = '0;
    hall_press = '0;
    repeat (2) step();
    rst = 1'b1;
    kill = 1'b0;
    step();
  endtask

  task automatic press(input logic [5:0] c, input logic [9:0] h);
    car_press = c;
    hall_press = h;
    step();
    car_press = '0;
    hall_press = '0;
  endtask

  task automatic wait_door(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (door_open) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_close(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (!door_open) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    kill = 1'b1;
    step();
    checks++;
    if ({cur_floor, dir, door_open, moving} !== 7'd0) begin
      errors++;
      $display("FAIL reset_state: got floor=%0d dir=%b door=%b moving=%b expected 0/00/0/0", cur_floor, dir, door_open, moving);
    end
    checks++;
    if ({clr_in, clr_out} !== 16'd0) begin
      errors++;
      $display("FAIL reset_clr: got clr_in=%b clr_out=%b expected zeros", clr_in, clr_out);
    end
    rst = 1'b1;
    kill = 1'b0;
    step();
  endtask

  task automatic test_single_stop();
    int n;
    do_reset();
    press(6'b000001, '0);
    step();
    checks++;
    if (!(door_open === 1'b1 && clr_in === 6'b000001 && clr_out === 10'd0 && cur_floor === 3'd0 && dir === 2'b00)) begin
      errors++;
      $display("FAIL single_open: got door=%b clr_in=%b clr_out=%b floor=%0d dir=%b expected 1/000001/0/0/00", door_open, clr_in, clr_out, cur_floor, dir);
    end
    step();
    checks++;
    if (clr_in !== 6'b0 || door_open !== 1'b1) begin
      errors++;
      $display("FAIL single_pulse_width: got clr_in=%b door=%b expected 000000/1", clr_in, door_open);
    end
    wait_close(10, n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL single_dwell: got %0d remaining open cycles expected 2", n);
    end
    checks++;
    if (dir !== 2'b00 || moving !== 1'b0 || cur_floor !== 3'd0) begin
      errors++;
      $display("FAIL single_idle: got dir=%b moving=%b floor=%0d expected 00/0/0", dir, moving, cur_floor);
    end
  endtask

  task automatic test_sweep_up();
    int n;
    do_reset();
    press(6'b101010, '0);
    step();
    checks++;
    if (moving !== 1'b1 || dir !== 2'b01 || cur_floor !== 3'd0) begin
      errors++;
      $display("FAIL sweep_start: got moving=%b dir=%b floor=%0d expected 1/01/0", moving, dir, cur_floor);
    end
    wait_door(20, n);
    checks++;
    if (n !== 4 || cur_floor !== 3'd1 || clr_in !== 6'b000010) begin
      errors++;
      $display("FAIL sweep_stop1: got cycles=%0d floor=%0d clr_in=%b expected 4/1/000010", n, cur_floor, clr_in);
    end
    wait_close(10, n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL sweep_dwell1: got %0d expected 3", n);
    end
    wait_door(30, n);
    checks++;
    if (n !== 8 || cur_floor !== 3'd3 || clr_in !== 6'b001000) begin
      errors++;
      $display("FAIL sweep_stop3: got cycles=%0d floor=%0d clr_in=%b expected 8/3/001000", n, cur_floor, clr_in);
    end
    wait_close(10, n);
    wait_door(30, n);
    checks++;
    if (n !== 8 || cur_floor !== 3'd5 || clr_in !== 6'b100000) begin
      errors++;
      $display("FAIL sweep_stop5: got cycles=%0d floor=%0d clr_in=%b expected 8/5/100000", n, cur_floor, clr_in);
    end
    wait_close(10, n);
    checks++;
    if (n !== 3 || cur_floor !== 3'd5 || dir !== 2'b00 || moving !== 1'b0) begin
      errors++;
      $display("FAIL sweep_end: got dwell=%0d floor=%0d dir=%b moving=%b expected 3/5/00/0", n, cur_floor, dir, moving);
    end
  endtask

  task automatic test_reverse();
    int n;
    do_reset();
    press(6'b010000, 10'b0000010000);
    step();
    wait_door(40, n);
    checks++;
    if (n !== 16 || cur_floor !== 3'd4 || clr_in !== 6'b010000 || clr_out !== 10'd0 || dir !== 2'b10) begin
      errors++;
      $display("FAIL reverse_top: got cycles=%0d floor=%0d clr_in=%b clr_out=%b dir=%b expected 16/4/010000/0/10", n, cur_floor, clr_in, clr_out, dir);
    end
    wait_close(10, n);
    wait_door(30, n);
    checks++;
    if (n !== 8 || cur_floor !== 3'd2 || clr_out !== 10'b0000010000 || clr_in !== 6'd0) begin
      errors++;
      $display("FAIL reverse_f2: got cycles=%0d floor=%0d clr_out=%b clr_in=%b expected 8/2/0000010000/0", n, cur_floor, clr_out, clr_in);
    end
    wait_close(10, n);
    checks++;
    if (n !== 3 || dir !== 2'b00 || moving !== 1'b0) begin
      errors++;
      $display("FAIL reverse_idle: got dwell=%0d dir=%b moving=%b expected 3/00/0", n, dir, moving);
    end
  endtask

  task automatic test_top_floor();
    int n;
    do_reset();
    press(6'b100000, '0);
    step();
    wait_door(40, n);
    checks++;
    if (n !== 20 || cur_floor !== 3'd5) begin
      errors++;
      $display("FAIL top_arrive: got cycles=%0d floor=%0d expected 20/5", n, cur_floor);
    end
    wait_close(10, n);
    press('0, 10'b1000000000);
    step();
    checks++;
    if (door_open !== 1'b1 || clr_out !== 10'b1000000000 || cur_floor !== 3'd5) begin
      errors++;
      $display("FAIL top_hall: got door=%b clr_out=%b floor=%0d expected 1/1000000000/5", door_open, clr_out, cur_floor);
    end
    wait_close(10, n);
    repeat (3) step();
    checks++;
    if (n !== 3 || cur_floor !== 3'd5 || moving !== 1'b0 || dir !== 2'b00) begin
      errors++;
      $display("FAIL top_stay: got dwell=%0d floor=%0d moving=%b dir=%b expected 3/5/0/00", n, cur_floor, moving, dir);
    end
  endtask

  task automatic test_reset_mid_move();
    int n;
    do_reset();
    press(6'b100000, '0);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (cur_floor == 3'd2) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL midreset_reach2: got timeout expected floor 2");
    end
    repeat (2) step();
    rst = 1'b0;
    #1;
    checks++;
    if (cur_floor !== 3'd0 || moving !== 1'b0 || dir !== 2'b00 || door_open !== 1'b0 || clr_in !== 6'd0 || clr_out !== 10'd0) begin
      errors++;
      $display("FAIL midreset_async: got floor=%0d moving=%b dir=%b door=%b clr_in=%b clr_out=%b expected all zero", cur_floor, moving, dir, door_open, clr_in, clr_out);
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if (moving !== 1'b1 || dir !== 2'b01 || cur_floor !== 3'd0 || clr_in !== 6'd0) begin
      errors++;
      $display("FAIL midreset_resume: got moving=%b dir=%b floor=%0d clr_in=%b expected 1/01/0/0", moving, dir, cur_floor, clr_in);
    end
    wait_door(40, n);
    checks++;
    if (n !== 20 || cur_floor !== 3'd5 || clr_in !== 6'b100000) begin
      errors++;
      $display("FAIL midreset_serve: got cycles=%0d floor=%0d clr_in=%b expected 20/5/100000", n, cur_floor, clr_in);
    end
    wait_close(10, n);
  endtask

  task automatic test_dwell_restart();
    int n;
    do_reset();
    press(6'b000001, '0);
    step();
    press(6'b000001, '0);
    checks++;
    if (clr_in !== 6'd0 || door_open !== 1'b1) begin
      errors++;
      $display("FAIL repress_gap: got clr_in=%b door=%b expected 000000/1", clr_in, door_open);
    end
    step();
    checks++;
    if (clr_in !== 6'b000001 || door_open !== 1'b1) begin
      errors++;
      $display("FAIL repress_pulse: got clr_in=%b door=%b expected 000001/1", clr_in, door_open);
    end
    wait_close(10, n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL repress_dwell: got %0d expected 3", n);
    end
  endtask

  task automatic test_door_hold();
    int n;
    int cnt;
    do_reset();
    press(6'b000001, '0);
    step();
    cnt = door_open ? 1 : 0;
`ifdef DOOR_HOLD_EN
    door_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (door_open) cnt++;
    end
    door_hold = 1'b0;
    wait_close(20, n);
    if (n > 0) cnt = cnt + n - 1;
    checks++;
    if (cnt !== 13) begin
      errors++;
      $display("FAIL door_hold: got %0d open cycles expected 13", cnt);
    end
`else
    wait_close(20, n);
    if (n > 0) cnt = cnt + n - 1;
    checks++;
    if (cnt !== 3) begin
      errors++;
      $display("FAIL door_fixed: got %0d open cycles expected 3", cnt);
    end
`endif
  endtask

  initial begin
    rst = 1'b0;
    kill = 1'b1;
    car_press = '0;
    hall_press = '0;
`ifdef DOOR_HOLD_EN
    door_hold = 1'b0;
`endif
    test_reset();
    test_single_stop();
    test_sweep_up();
    test_reverse();
    test_top_floor();
    test_reset_mid_move();
    test_dwell_restart();
    test_door_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
